// File: rtl/phase_wave_gen.sv
// phase_wave_gen
// Generates NUM_CH phase-shifted 40 kHz square waves for a transducer array.
// Phase bytes arrive one per byte_valid strobe and fill a shadow bank. An apply
// request copies the shadow bank into the active bank at the next period
// boundary, so an output never changes phase in the middle of a period.
//
// Ports
//   master_clock   : sole clock, rising edge
//   rst            : synchronous active-high reset
//   byte_data      : phase byte (0..STEPS-1 = phase step, >= STEPS = channel off)
//   byte_valid     : qualifies byte_data for one cycle
//   frame_start    : restarts the channel write index at 0
//   apply          : requests a shadow-to-active transfer at the next boundary
//   transducer_out : registered square-wave drive, bit i = channel i
//   frame_done     : NUM_CH bytes received in the current frame
//   overrun        : sticky, a byte arrived after the frame was already full
//   apply_pending  : transfer requested but not yet performed
module phase_wave_gen #(
  parameter int NUM_CH  = 50,
  parameter int CLK_DIV = 5,
  parameter int STEPS   = 250
) (
  input  logic              master_clock,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              frame_start,
  input  logic              apply,
  output logic [NUM_CH-1:0] transducer_out,
  output logic              frame_done,
  output logic              overrun,
  output logic              apply_pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = $clog2(NUM_CH + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [8:0]    STEP_MAX  = 9'(STEPS - 1);
  localparam logic [8:0]    STEPS_9   = 9'(STEPS);
  localparam logic [8:0]    HALF_9    = 9'(STEPS / 2);
  localparam logic [WW-1:0] W_FULL    = WW'(NUM_CH);
  localparam logic [WW-1:0] W_LAST    = WW'(NUM_CH - 1);

  // High while (step - phase) mod STEPS lies in the first half period.
  // The 9-bit difference is negative exactly when bit 8 is set.
  function automatic logic phase_on(input logic [8:0] step, input logic [7:0] phase);
    logic [8:0] diff;
    logic       on;
    diff = step - {1'b0, phase};
    if (diff[8]) begin
      diff = diff + STEPS_9;
    end else begin
      diff = diff;
    end
    if ({1'b0, phase} >= STEPS_9) begin
      on = 1'b0;
    end else begin
      on = (diff < HALF_9);
    end
    return on;
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [8:0]        step_q, step_d;
  logic [WW-1:0]     w_q, w_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;
  logic [NUM_CH-1:0] wave_q, wave_d;
  logic [7:0]        shadow_q [NUM_CH];
  logic [7:0]        active_q [NUM_CH];

  logic              boundary_s;
  logic              xfer_s;
  logic              wr_en_s;
  logic [WW-1:0]     wr_idx_s;

  // Prescaler and phase-step counter that define the 40 kHz period.
  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = {PW{1'b0}};
      if (step_q == STEP_MAX) begin
        step_d = 9'd0;
      end else begin
        step_d = step_q + 9'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  assign boundary_s = (step_q == 9'd0) && (presc_q == {PW{1'b0}});
  // A request arriving in the boundary cycle itself only sets pending, so it
  // waits for the following boundary.
  assign xfer_s     = boundary_s && pending_q;

  // Frame write index, shadow write enable, frame_done and overrun flags.
  always_comb begin
    w_d          = w_q;
    wr_en_s      = 1'b0;
    wr_idx_s     = w_q;
    frame_done_d = frame_done_q;
    overrun_d    = overrun_q;
    if (frame_start) begin
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      if (byte_valid) begin
        wr_en_s  = 1'b1;
        wr_idx_s = {WW{1'b0}};
        w_d      = WW'(1);
      end else begin
        w_d = {WW{1'b0}};
      end
    end else if (byte_valid) begin
      if (w_q < W_FULL) begin
        wr_en_s = 1'b1;
        w_d     = w_q + WW'(1);
        if (w_q == W_LAST) begin
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = frame_done_q;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      w_d = w_q;
    end
  end

  // Apply request latch; further requests while pending are absorbed.
  always_comb begin
    if (xfer_s) begin
      pending_d = 1'b0;
    end else if (apply) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Next output bits. During a transfer cycle the incoming shadow phases are
  // used so the first period after the boundary is already complete.
  always_comb begin
    wave_d = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      wave_d[i] = phase_on(step_q, xfer_s ? shadow_q[i] : active_q[i]);
    end
  end

  // Control and output registers.
  always_ff @(posedge master_clock) begin
    if (rst) begin
      presc_q      <= {PW{1'b0}};
      step_q       <= 9'd0;
      w_q          <= {WW{1'b0}};
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      pending_q    <= 1'b0;
      wave_q       <= {NUM_CH{1'b0}};
    end else begin
      presc_q      <= presc_d;
      step_q       <= step_d;
      w_q          <= w_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      pending_q    <= pending_d;
      wave_q       <= wave_d;
    end
  end

  // Shadow bank, written one byte at a time.
  always_ff @(posedge master_clock) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= 8'hFF;
      end
    end else if (wr_en_s) begin
      shadow_q[wr_idx_s] <= byte_data;
    end
  end

  // Active bank, loaded from the pre-edge shadow contents at a boundary.
  always_ff @(posedge master_clock) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= 8'hFF;
      end
    end else if (xfer_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  assign transducer_out = wave_q;
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;
  assign apply_pending  = pending_q;

endmodule

// File: tb/tb_phase_wave_gen.sv
// Directed bench for phase_wave_gen with default parameters
// (50 channels, 5 clocks per step, 250 steps -> 1250-cycle period).
// cyc numbers the cycle whose state is visible #1 after the last edge;
// cycle 0 is the first cycle after reset, a period boundary.
module tb_phase_wave_gen;

  localparam logic [49:0] ALL1 = {50{1'b1}};
  localparam logic [49:0] ZERO = {50{1'b0}};

  logic        master_clock = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        apply = 1'b0;
  logic [49:0] transducer_out;
  logic        frame_done;
  logic        overrun;
  logic        apply_pending;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  phase_wave_gen dut (
    .master_clock   (master_clock),
    .rst            (rst),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .frame_start    (frame_start),
    .apply          (apply),
    .transducer_out (transducer_out),
    .frame_done     (frame_done),
    .overrun        (overrun),
    .apply_pending  (apply_pending)
  );

  always #5 master_clock = ~master_clock;

  task automatic tick();
    @(posedge master_clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic pulse_apply();
    apply = 1'b1;
    tick();
    apply = 1'b0;
  endtask

  // frame_start together with byte 0, then bytes 1..49: 50 cycles.
  task automatic load_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] rest);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = b0;
    tick();
    frame_start = 1'b0;
    send_byte(b1);
    for (int i = 2; i < 50; i++) send_byte(rest);
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_cmp++;
    if ({transducer_out, frame_done, overrun, apply_pending} !== 53'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {transducer_out, frame_done, overrun, apply_pending});
    end
    bad = 0;
    for (int k = 0; k < 2500; k++) begin
      if ({transducer_out, frame_done, apply_pending} !== 52'd0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL idle_2500: got %0d nonzero cycles want 0", bad);
    end
  endtask

  task automatic test_all_zero();
    int bad;
    do_reset();
    load_frame(8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_frame_done: got %b want 1", frame_done);
    end
    pulse_apply();
    n_cmp++;
    if (apply_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_pending_set: got %b want 1", apply_pending);
    end
    run_to(1250);
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b1, ZERO}) begin
      n_bad++;
      $display("FAIL zero_at_boundary: got %h want %h", {apply_pending, transducer_out}, {1'b1, ZERO});
    end
    tick();
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b0, ALL1}) begin
      n_bad++;
      $display("FAIL zero_after_xfer: got %h want %h", {apply_pending, transducer_out}, {1'b0, ALL1});
    end
    bad = 0;
    for (int k = 0; k < 2500; k++) begin
      if (transducer_out !== ((((cyc - 1251) % 1250) < 625) ? ALL1 : ZERO)) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL zero_wave_625: got %0d wrong cycles want 0", bad);
    end
  endtask

  task automatic test_two_channel();
    int          pts [6];
    logic [1:0]  exp_lo [6];
    logic [49:0] e;
    pts    = '{1565, 1566, 1875, 1876, 2190, 2191};
    exp_lo = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    do_reset();
    load_frame(8'h00, 8'h3F, 8'hFF);
    pulse_apply();
    run_to(1251);
    n_cmp++;
    if (transducer_out !== 50'd1) begin
      n_bad++;
      $display("FAIL two_ch_start: got %h want %h", transducer_out, 50'd1);
    end
    for (int k = 0; k < 6; k++) begin
      run_to(pts[k]);
      e = ZERO;
      e[1:0] = exp_lo[k];
      n_cmp++;
      if (transducer_out !== e) begin
        n_bad++;
        $display("FAIL two_ch_c%0d: got %h want %h", pts[k], transducer_out, e);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 49; i++) send_byte(8'hFF);
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_done_49: got %b want 0", frame_done);
    end
    send_byte(8'h00);
    n_cmp++;
    if ({frame_done, overrun} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovr_after_50: got %b want 10", {frame_done, overrun});
    end
    send_byte(8'h7D);
    n_cmp++;
    if ({frame_done, overrun} !== 2'b11) begin
      n_bad++;
      $display("FAIL ovr_after_51: got %b want 11", {frame_done, overrun});
    end
    pulse_apply();
    run_to(1251);
    n_cmp++;
    if (transducer_out !== {1'b1, 49'd0}) begin
      n_bad++;
      $display("FAIL ovr_shadow49: got %h want %h", transducer_out, {1'b1, 49'd0});
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_cmp++;
    if ({frame_done, overrun} !== 2'b00) begin
      n_bad++;
      $display("FAIL ovr_clear: got %b want 00", {frame_done, overrun});
    end
  endtask

  task automatic test_boundary_apply();
    do_reset();
    load_frame(8'h00, 8'h00, 8'h00);
    run_to(1250);
    pulse_apply();
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b1, ZERO}) begin
      n_bad++;
      $display("FAIL bnd_deferred: got %h want %h", {apply_pending, transducer_out}, {1'b1, ZERO});
    end
    run_to(1300);
    pulse_apply();
    run_to(2500);
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b1, ZERO}) begin
      n_bad++;
      $display("FAIL bnd_before_xfer: got %h want %h", {apply_pending, transducer_out}, {1'b1, ZERO});
    end
    tick();
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b0, ALL1}) begin
      n_bad++;
      $display("FAIL bnd_xfer: got %h want %h", {apply_pending, transducer_out}, {1'b0, ALL1});
    end
    run_to(3000);
    n_cmp++;
    if (apply_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL bnd_single_xfer: got %b want 0", apply_pending);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 25; i++) send_byte(8'h00);
    pulse_apply();
    n_cmp++;
    if (apply_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pending: got %b want 1", apply_pending);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    apply      = 1'b1;
    do_reset();
    byte_valid = 1'b0;
    apply      = 1'b0;
    n_cmp++;
    if ({transducer_out, frame_done, overrun, apply_pending} !== 53'd0) begin
      n_bad++;
      $display("FAIL mid_reset_state: got %h want 0", {transducer_out, frame_done, overrun, apply_pending});
    end
    run_to(1251);
    n_cmp++;
    if ({apply_pending, transducer_out} !== {1'b0, ZERO}) begin
      n_bad++;
      $display("FAIL mid_no_xfer: got %h want 0", {apply_pending, transducer_out});
    end
    send_byte(8'h00);
    for (int i = 1; i < 50; i++) send_byte(8'hFF);
    n_cmp++;
    if ({frame_done, overrun} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_index0: got %b want 10", {frame_done, overrun});
    end
    pulse_apply();
    run_to(2501);
    n_cmp++;
    if (transducer_out !== 50'd1) begin
      n_bad++;
      $display("FAIL mid_ch0_only: got %h want %h", transducer_out, 50'd1);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_two_channel();
    test_overrun();
    test_boundary_apply();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
